detector_jogada: RTL and testbench
==================================

# detector_jogada

Input-conditioning stage that sits directly upstream of the memory-game datapath/control pair. It synchronizes and debounces the four raw push-buttons, then classifies each press as valid (exactly one button) or invalid. It delivers a registered 4-bit one-hot play value (`jogada`, wired to the datapath's `chaves`) together with a single-cycle strobe the control unit consumes as "play made". It also exposes its FSM state for the HEX debug display.

## Interface
- `DEBOUNCE_CYCLES`, default 50000 (1 ms at 50 MHz): consecutive stable samples required before a button vector is accepted; legal range ≥ 2.
- `clock`  in  1  single system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `botoes`  in  4  raw asynchronous push-buttons, 1 = pressed.
- `habilita`  in  1  from the control unit; 1 = accept new plays.
- `jogada`  out  4  last accepted one-hot play, registered; reset 4'b0000.
- `jogada_feita`  out  1  one-cycle strobe, valid play captured; reset 0.
- `jogada_invalida`  out  1  one-cycle strobe, more than one button pressed; reset 0.
- `db_estado`  out  4  current FSM state code; reset 4'h1.

## Operation
- Synchronizer: 2-flop per bit, producing `sinc[3:0]`.
- Debouncer: holds candidate vector `cand` and counter `cnt` (width `$clog2(DEBOUNCE_CYCLES)`).
  - If `sinc != cand`, load `cand <= sinc` and `cnt <= 0`.
  - Otherwise `cnt` increments, saturating at `DEBOUNCE_CYCLES-1` with no wrap.
  - When `cnt` reaches `DEBOUNCE_CYCLES-1`, `estavel <= cand`.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches `estavel`.
- FSM states and codes:
  - ESPERA 4'h1
    - `estavel == 0`: stay.
    - `estavel != 0 && habilita && one-hot`: go to REGISTRA.
    - `estavel != 0 && habilita && not one-hot`: go to INVALIDA.
    - `estavel != 0 && !habilita`: go to SOLTAR. The press is ignored and is never captured later, even if `habilita` rises while the button is still held.
  - REGISTRA 4'h2: `jogada <= estavel`, `jogada_feita = 1` for this state's cycle; then go to SOLTAR.
  - INVALIDA 4'h3: `jogada_invalida = 1` for this state's cycle; `jogada` unchanged; then go to SOLTAR.
  - SOLTAR 4'h4: wait for `estavel == 0`, then go to ESPERA. Adding or removing buttons while in this state generates nothing.
  - Unused codes go to ESPERA.
- `jogada` holds its value between plays. Only REGISTRA writes it.
- `jogada_feita` and `jogada_invalida` are decoded from the registered state (Moore) and are never both high.
- `db_estado` equals the state register.

## Timing
- Reset is asynchronous: the synchronizer, `cand`, `cnt`, `estavel`, FSM and `jogada` all clear at once, and the state returns to ESPERA.
  - Reset mid-press: after release, no strobe is generated for the press that was in progress unless it is still held once `reset` = 1, in which case it is re-debounced as a fresh press.
- Latency: `botoes` changes and is held stable, first sampled at rising edge k.
  - `sinc` updates at k+1.
  - `estavel` updates at edge k+1+`DEBOUNCE_CYCLES`.
  - The FSM enters REGISTRA/INVALIDA at the following edge.
  - The strobe is therefore high in the cycle after edge k+2+`DEBOUNCE_CYCLES`.
- Release follows the same path, so the minimum press-to-next-press spacing is about 2×(`DEBOUNCE_CYCLES`+2) cycles.
- `habilita` is sampled only in ESPERA, on the same edge that evaluates `estavel`.
- At most one strobe per press-release cycle; holding a button indefinitely yields exactly one strobe.

## Structure
- Shared package `jogo_pkg`: state codes ESPERA/REGISTRA/INVALIDA/SOLTAR as 4-bit localparams (codes are also shown on HEX5), plus a `one_hot4` function.
- Sub-module `debouncer_botoes`: synchronizer plus counter, parameter `DEBOUNCE_CYCLES`, output `estavel[3:0]`. The FSM stays in `detector_jogada`.
- `db_estado` is routed to the existing `hexa7seg` instance at top level; no display decoding happens inside this block.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`.
- Reset then idle: `reset` = 0 for 2 cycles, then 1.
  - `jogada` = 0, both strobes 0, `db_estado` = 4'h1, throughout and after.
- Clean press: `botoes` = 4'b0100 held, `habilita` = 1.
  - `jogada_feita` high for exactly 1 cycle, 7 cycles after the first sampling edge.
  - `jogada` = 4'b0100 from then on; `db_estado` sequence 1 → 2 → 4, then 1 after release.
- Bounce: `botoes` toggles 0010/0000 every 2 cycles for 10 cycles, then holds 0010.
  - Exactly one `jogada_feita`, with `jogada` = 4'b0010, timed from the final stable edge.
- Invalid press: `botoes` = 4'b0101.
  - `jogada_invalida` pulses once; `jogada` keeps its previous value (4'b0010); `jogada_feita` never asserts.
- Disabled press: `habilita` = 0, press 4'b1000; raise `habilita` while held; then release and press 4'b0001.
  - No strobe for 4'b1000; one `jogada_feita` with `jogada` = 4'b0001.
- Async reset mid-debounce: press 4'b0001, drop `reset` 2 cycles after the first sampling edge while holding, release reset, keep holding.
  - Outputs clear immediately; one `jogada_feita` arrives 7 cycles after the first post-reset sampling edge.

Source files
------------

// File: rtl/jogo_pkg.sv
// jogo_pkg: definitions shared by the memory-game input stage.
//   estado_t - detector FSM state codes (also shown on the HEX debug display)
//   one_hot4 - 1 when exactly one bit of a 4-bit vector is set
package jogo_pkg;

  typedef enum logic [3:0] {
    ESPERA   = 4'h1,
    REGISTRA = 4'h2,
    INVALIDA = 4'h3,
    SOLTAR   = 4'h4
  } estado_t;

  function automatic logic one_hot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/debouncer_botoes.sv
// debouncer_botoes: 2-flop synchronizer plus stability counter for 4 buttons.
//   clock   - system clock, rising edge
//   reset   - asynchronous, active-low
//   botoes  - raw push-buttons, 1 = pressed
//   estavel - button vector after it stayed unchanged for DEBOUNCE_CYCLES
//             consecutive synchronized samples
module debouncer_botoes #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  output logic [3:0] estavel
);

  localparam int unsigned    CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    sinc1_q, sinc1_d;
  logic [3:0]    sinc_q,  sinc_d;
  logic [3:0]    cand_q,  cand_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [3:0]    estavel_q, estavel_d;

  always_comb begin
    sinc1_d   = botoes;
    sinc_d    = sinc1_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    estavel_d = estavel_q;
    if (sinc_q != cand_q) begin
      cand_d = sinc_q;
      cnt_d  = '0;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
      // Accept on the edge the count reaches its ceiling, so the candidate
      // has been seen DEBOUNCE_CYCLES times in a row (load sample included).
      if (cnt_d == CNT_MAX) begin
        estavel_d = cand_q;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc1_q   <= '0;
      sinc_q    <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      estavel_q <= '0;
    end else begin
      sinc1_q   <= sinc1_d;
      sinc_q    <= sinc_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      estavel_q <= estavel_d;
    end
  end

  assign estavel = estavel_q;

endmodule

// File: rtl/detector_jogada.sv
// detector_jogada: classifies debounced button presses for the memory game.
//   clock           - system clock, rising edge
//   reset           - asynchronous, active-low
//   botoes          - raw push-buttons, 1 = pressed
//   habilita        - 1 = control unit accepts new plays
//   jogada          - last accepted one-hot play (held between plays)
//   jogada_feita    - one-cycle strobe, valid play captured
//   jogada_invalida - one-cycle strobe, more than one button pressed
//   db_estado       - current FSM state code for the debug display
module detector_jogada
  import jogo_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       habilita,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       jogada_invalida,
  output logic [3:0] db_estado
);

  logic [3:0] estavel;

  debouncer_botoes #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock   (clock),
    .reset   (reset),
    .botoes  (botoes),
    .estavel (estavel)
  );

  estado_t    estado_q, estado_d;
  logic [3:0] jogada_q, jogada_d;

  always_comb begin
    estado_d = estado_q;
    jogada_d = jogada_q;
    case (estado_q)
      ESPERA: begin
        // A press seen while disabled goes straight to SOLTAR so it can never
        // be captured later, even if habilita rises while still held.
        if (estavel != 4'b0000) begin
          if (!habilita)               estado_d = SOLTAR;
          else if (one_hot4(estavel))  estado_d = REGISTRA;
          else                         estado_d = INVALIDA;
        end
      end
      REGISTRA: begin
        jogada_d = estavel;
        estado_d = SOLTAR;
      end
      INVALIDA: estado_d = SOLTAR;
      SOLTAR: begin
        if (estavel == 4'b0000) estado_d = ESPERA;
      end
      default: estado_d = ESPERA;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= ESPERA;
      jogada_q <= '0;
    end else begin
      estado_q <= estado_d;
      jogada_q <= jogada_d;
    end
  end

  assign jogada          = jogada_q;
  assign jogada_feita    = (estado_q == REGISTRA);
  assign jogada_invalida = (estado_q == INVALIDA);
  assign db_estado       = estado_q;

endmodule

// File: tb/tb_detector_jogada.sv
module tb_detector_jogada;

  localparam int unsigned D = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] botoes = 4'b0000;
  logic       habilita = 1'b0;
  logic [3:0] jogada;
  logic       jogada_feita;
  logic       jogada_invalida;
  logic [3:0] db_estado;

  always #5 clock = ~clock;

  detector_jogada #(.DEBOUNCE_CYCLES(D)) dut (
    .clock           (clock),
    .reset           (reset),
    .botoes          (botoes),
    .habilita        (habilita),
    .jogada          (jogada),
    .jogada_feita    (jogada_feita),
    .jogada_invalida (jogada_invalida),
    .db_estado       (db_estado)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a button vector becomes "stable" once the last D
  // synchronized samples agree; the game state is tracked as plain codes.
  logic [3:0] m_hist[$];
  logic [3:0] m_est;
  logic [3:0] m_jog;
  int         m_st;

  task automatic model_clear();
    m_hist.delete();
    for (int i = 0; i < D + 1; i++) m_hist.push_back(4'b0000);
    m_est = 4'b0000;
    m_jog = 4'b0000;
    m_st  = 1;
  endtask

  function automatic logic [9:0] m_exp();
    return {m_jog, (m_st == 2), (m_st == 3), 4'(m_st)};
  endfunction

  // Advance one clock edge, update the model, land 1 time unit after the edge.
  task automatic tick();
    logic all_eq;
    @(posedge clock);
    if (!reset) begin
      model_clear();
    end else begin
      case (m_st)
        1: if (m_est != 4'b0000)
             m_st = habilita ? (($countones(m_est) == 1) ? 2 : 3) : 4;
        2: begin m_jog = m_est; m_st = 4; end
        3: m_st = 4;
        4: if (m_est == 4'b0000) m_st = 1;
        default: m_st = 1;
      endcase
      // m_hist[0..D-1] are the samples that reached the synchronizer output
      // during the last D cycles
      all_eq = 1'b1;
      for (int i = 1; i < D; i++) if (m_hist[i] != m_hist[0]) all_eq = 1'b0;
      if (all_eq) m_est = m_hist[0];
      m_hist.push_back(botoes);
      void'(m_hist.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    for (int t = 0; t < 2; t++) begin
      tick();
      n_tests++;
      if ({jogada, jogada_feita, jogada_invalida, db_estado} !== 10'b0000_0_0_0001) begin
        n_fail++;
        $display("FAIL reset_hold got=%b exp=%b", {jogada, jogada_feita, jogada_invalida, db_estado}, 10'b0000_0_0_0001);
      end
    end
    #2 reset = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      n_tests++;
      if ({jogada, jogada_feita, jogada_invalida, db_estado} !== 10'b0000_0_0_0001) begin
        n_fail++;
        $display("FAIL reset_idle got=%b exp=%b", {jogada, jogada_feita, jogada_invalida, db_estado}, 10'b0000_0_0_0001);
      end
    end
  endtask

  task automatic test_clean_press();
    int first = -1;
    int cnt = 0;
    logic [3:0] trace[$];
    logic [3:0] last = 4'h1;
    trace.push_back(4'h1);
    habilita = 1'b1;
    botoes = 4'b0100;
    for (int t = 1; t <= 24; t++) begin
      if (t == 13) botoes = 4'b0000;
      tick();
      n_tests++;
      if ({jogada, jogada_feita, jogada_invalida, db_estado} !== m_exp()) begin
        n_fail++;
        $display("FAIL clean_cycle t=%0d got=%b exp=%b", t, {jogada, jogada_feita, jogada_invalida, db_estado}, m_exp());
      end
      if (jogada_feita) begin cnt++; if (first < 0) first = t; end
      if (db_estado != last) begin trace.push_back(db_estado); last = db_estado; end
    end
    n_tests++;
    if (cnt != 1 || first != 7) begin
      n_fail++;
      $display("FAIL clean_strobe got count=%0d at=%0d exp count=1 at=7", cnt, first);
    end
    n_tests++;
    if (jogada !== 4'b0100) begin
      n_fail++;
      $display("FAIL clean_jogada got=%b exp=0100", jogada);
    end
    n_tests++;
    if (trace.size() != 4 || trace[0] != 4'h1 || trace[1] != 4'h2 || trace[2] != 4'h4 || trace[3] != 4'h1) begin
      n_fail++;
      $display("FAIL clean_states got=%p exp=1,2,4,1", trace);
    end
  endtask

  task automatic test_bounce();
    int first = -1;
    int cnt = 0;
    for (int t = 1; t <= 36; t++) begin
      if (t <= 10) botoes = (((t - 1) / 2) % 2 == 0) ? 4'b0010 : 4'b0000;
      if (t == 25) botoes = 4'b0000;
      tick();
      n_tests++;
      if ({jogada, jogada_feita, jogada_invalida, db_estado} !== m_exp()) begin
        n_fail++;
        $display("FAIL bounce_cycle t=%0d got=%b exp=%b", t, {jogada, jogada_feita, jogada_invalida, db_estado}, m_exp());
      end
      if (jogada_feita) begin cnt++; if (first < 0) first = t; end
    end
    n_tests++;
    if (cnt != 1 || first != 15 || jogada !== 4'b0010) begin
      n_fail++;
      $display("FAIL bounce_strobe got count=%0d at=%0d jogada=%b exp count=1 at=15 jogada=0010", cnt, first, jogada);
    end
  endtask

  task automatic test_invalid();
    int n_inv = 0;
    int n_ok = 0;
    botoes = 4'b0101;
    for (int t = 1; t <= 24; t++) begin
      if (t == 13) botoes = 4'b0000;
      tick();
      n_tests++;
      if ({jogada, jogada_feita, jogada_invalida, db_estado} !== m_exp()) begin
        n_fail++;
        $display("FAIL invalid_cycle t=%0d got=%b exp=%b", t, {jogada, jogada_feita, jogada_invalida, db_estado}, m_exp());
      end
      if (jogada_invalida) n_inv++;
      if (jogada_feita) n_ok++;
    end
    n_tests++;
    if (n_inv != 1 || n_ok != 0 || jogada !== 4'b0010) begin
      n_fail++;
      $display("FAIL invalid_strobe got inv=%0d feita=%0d jogada=%b exp inv=1 feita=0 jogada=0010", n_inv, n_ok, jogada);
    end
  endtask

  task automatic test_disabled();
    int n_ok_held = 0;
    int n_ok = 0;
    int n_inv = 0;
    habilita = 1'b0;
    botoes = 4'b1000;
    for (int t = 1; t <= 56; t++) begin
      if (t == 13) habilita = 1'b1;
      if (t == 21) botoes = 4'b0000;
      if (t == 33) botoes = 4'b0001;
      if (t == 45) botoes = 4'b0000;
      tick();
      n_tests++;
      if ({jogada, jogada_feita, jogada_invalida, db_estado} !== m_exp()) begin
        n_fail++;
        $display("FAIL disabled_cycle t=%0d got=%b exp=%b", t, {jogada, jogada_feita, jogada_invalida, db_estado}, m_exp());
      end
      if (jogada_feita) begin n_ok++; if (t <= 32) n_ok_held++; end
      if (jogada_invalida) n_inv++;
    end
    n_tests++;
    if (n_ok_held != 0 || n_ok != 1 || n_inv != 0 || jogada !== 4'b0001) begin
      n_fail++;
      $display("FAIL disabled_strobe got held=%0d feita=%0d inv=%0d jogada=%b exp held=0 feita=1 inv=0 jogada=0001", n_ok_held, n_ok, n_inv, jogada);
    end
  endtask

  task automatic test_reset_mid_press();
    int first = -1;
    int cnt = 0;
    botoes = 4'b0001;
    tick();
    tick();
    #2 reset = 1'b0;
    #1 model_clear();
    n_tests++;
    if ({jogada, jogada_feita, jogada_invalida, db_estado} !== 10'b0000_0_0_0001) begin
      n_fail++;
      $display("FAIL reset_async got=%b exp=%b", {jogada, jogada_feita, jogada_invalida, db_estado}, 10'b0000_0_0_0001);
    end
    tick();
    tick();
    #2 reset = 1'b1;
    for (int t = 1; t <= 24; t++) begin
      if (t == 13) botoes = 4'b0000;
      tick();
      n_tests++;
      if ({jogada, jogada_feita, jogada_invalida, db_estado} !== m_exp()) begin
        n_fail++;
        $display("FAIL reset_mid_cycle t=%0d got=%b exp=%b", t, {jogada, jogada_feita, jogada_invalida, db_estado}, m_exp());
      end
      if (jogada_feita) begin cnt++; if (first < 0) first = t; end
    end
    n_tests++;
    if (cnt != 1 || first != 7 || jogada !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_mid_strobe got count=%0d at=%0d jogada=%b exp count=1 at=7 jogada=0001", cnt, first, jogada);
    end
  endtask

  task automatic test_random();
    int hold;
    int sel;
    for (int seg = 0; seg < 300; seg++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3)      botoes = 4'b0000;
      else if (sel < 7) botoes = 4'b0001 << $urandom_range(0, 3);
      else              botoes = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) habilita = ~habilita;
      if ($urandom_range(0, 39) == 0) begin
        #2 reset = 1'b0;
        #1 model_clear();
        tick();
        #2 reset = 1'b1;
      end
      hold = $urandom_range(1, 10);
      for (int t = 0; t < hold; t++) begin
        tick();
        n_tests++;
        if ({jogada, jogada_feita, jogada_invalida, db_estado} !== m_exp()) begin
          n_fail++;
          $display("FAIL random_cycle seg=%0d got=%b exp=%b", seg, {jogada, jogada_feita, jogada_invalida, db_estado}, m_exp());
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_clean_press();
    test_bounce();
    test_invalid();
    test_disabled();
    test_reset_mid_press();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
